stage_mem: RTL



---
 rtl/stage_mem_pkg.sv | 33 +++
 rtl/stage_mem_if.sv | 18 +
 rtl/stage_mem_align.sv | 34 +++
 rtl/stage_mem.sv | 109 ++++++++++
 4 files changed

// File: rtl/stage_mem_pkg.sv
// stage_mem_pkg: operator codes, FSM states and wb register bundle for the memory stage.
package stage_mem_pkg;
  localparam logic [7:0] OPERATOR_LB  = 8'h20;
  localparam logic [7:0] OPERATOR_LH  = 8'h21;
  localparam logic [7:0] OPERATOR_LW  = 8'h23;
  localparam logic [7:0] OPERATOR_LBU = 8'h24;
  localparam logic [7:0] OPERATOR_LHU = 8'h25;
  localparam logic [7:0] OPERATOR_SB  = 8'h28;
  localparam logic [7:0] OPERATOR_SH  = 8'h29;
  localparam logic [7:0] OPERATOR_SW  = 8'h2B;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic RESET_ENABLE  = 1'b1;
  typedef enum logic {
    MEM_STATE_IDLE = 1'b0,
    MEM_STATE_WAIT = 1'b1
  } mem_state_e;
  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        hi_we;
    logic [31:0] hi_data;
    logic        lo_we;
    logic [31:0] lo_data;
  } wb_t;
  function automatic logic is_store_op(input logic [7:0] op);
    return op inside {OPERATOR_SB, OPERATOR_SH, OPERATOR_SW};
  endfunction
  function automatic logic is_mem_op(input logic [7:0] op);
    return is_store_op(op) || (op inside {OPERATOR_LB, OPERATOR_LBU, OPERATOR_LH, OPERATOR_LHU, OPERATOR_LW});
  endfunction
endpackage

// File: rtl/stage_mem_if.sv
// stage_mem_if: request/ack data bus between the memory stage (master) and memory (slave).
interface stage_mem_if;
  logic        bus_request;
  logic        bus_write;
  logic [31:0] bus_address;
  logic [3:0]  bus_byte_select;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data;
  logic        bus_ack;
  modport master (
    output bus_request, bus_write, bus_address, bus_byte_select, bus_write_data,
    input  bus_read_data, bus_ack
  );
  modport slave (
    input  bus_request, bus_write, bus_address, bus_byte_select, bus_write_data,
    output bus_read_data, bus_ack
  );
endinterface

// File: rtl/stage_mem_align.sv
// mem_align: big-endian lane select, store replication and load extension.
// MEM_UNALIGNED_TRAP_EN flags misaligned accesses; otherwise low address bits are aligned down.
module mem_align
  import stage_mem_pkg::*;
(
  input  logic [7:0]  operator_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] read_data_i,
  output logic [3:0]  byte_select_o,
  output logic [31:0] write_data_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);
  logic        byte_op, half_op, sext;
  logic [1:0]  off;
  logic [31:0] shifted;
  assign byte_op = operator_i inside {OPERATOR_LB, OPERATOR_LBU, OPERATOR_SB};
  assign half_op = operator_i inside {OPERATOR_LH, OPERATOR_LHU, OPERATOR_SH};
  assign sext    = operator_i inside {OPERATOR_LB, OPERATOR_LH};
`ifdef MEM_UNALIGNED_TRAP_EN
  assign off          = offset_i;
  assign misaligned_o = half_op ? offset_i[0] : (is_mem_op(operator_i) & ~byte_op & |offset_i);
`else
  assign off          = byte_op ? offset_i : half_op ? {offset_i[1], 1'b0} : 2'b00;
  assign misaligned_o = 1'b0;
`endif
  // selected lane lands in the top bits, so byte = [31:24] and half = [31:16]
  assign shifted       = read_data_i << {off, 3'b000};
  assign byte_select_o = byte_op ? 4'b1000 >> off : half_op ? (off[1] ? 4'b0011 : 4'b1100) : 4'b1111;
  assign write_data_o  = byte_op ? {4{store_data_i[7:0]}} : half_op ? {2{store_data_i[15:0]}} : store_data_i;
  assign load_data_o   = byte_op ? {{24{sext & shifted[31]}}, shifted[31:24]}
                       : half_op ? {{16{sext & shifted[31]}}, shifted[31:16]} : read_data_i;
endmodule

// File: rtl/stage_mem.sv
// stage_mem: memory-access stage; runs bus transactions for loads/stores with stall and timeout.
// Misalignment trapping is enabled by MEM_UNALIGNED_TRAP_EN (see mem_align).
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TIMER_WIDTH    = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic [7:0]         operator,
  input  logic [31:0]        memory_address,
  input  logic [31:0]        store_data,
  input  logic               register_write_enable_i,
  input  logic [4:0]         register_write_address_i,
  input  logic [31:0]        register_write_data_i,
  input  logic               register_hi_write_enable_i,
  input  logic               register_lo_write_enable_i,
  input  logic [31:0]        register_hi_write_data_i,
  input  logic [31:0]        register_lo_write_data_i,
  stage_mem_if.master        bus,
  output logic               stall_request,
  output logic               bus_error,
  output logic               address_error,
  output logic               mem_register_hi_write_enable,
  output logic               mem_register_lo_write_enable,
  output logic [31:0]        mem_register_hi_write_data,
  output logic [31:0]        mem_register_lo_write_data,
  output logic               wb_register_write_enable,
  output logic [4:0]         wb_register_write_address,
  output logic [31:0]        wb_register_write_data,
  output logic               wb_register_hi_write_enable,
  output logic [31:0]        wb_register_hi_write_data,
  output logic               wb_register_lo_write_enable,
  output logic [31:0]        wb_register_lo_write_data
);
  localparam logic [TIMER_WIDTH-1:0] TIMEOUT_T = TIMER_WIDTH'(TIMEOUT_CYCLES);
  mem_state_e             state_q, state_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d;
  wb_t                    wb_q, wb_d;
  logic                   bus_error_q, bus_error_d, address_error_q, address_error_d;
  logic                   mem_op, store_op, misaligned, live, access, commit;
  logic [31:0]            load_data;
  mem_align u_align (
    .operator_i    (operator),
    .offset_i      (memory_address[1:0]),
    .store_data_i  (store_data),
    .read_data_i   (bus.bus_read_data),
    .byte_select_o (bus.bus_byte_select),
    .write_data_o  (bus.bus_write_data),
    .load_data_o   (load_data),
    .misaligned_o  (misaligned)
  );
  assign mem_op   = is_mem_op(operator);
  assign store_op = is_store_op(operator);
  assign live     = mem_op & ~misaligned & ~flush & ~reset;
  // the request is withdrawn in the cycle the timer has reached its limit
  assign access   = live & (state_q == MEM_STATE_IDLE || timer_q != TIMEOUT_T);
  assign commit   = ~flush & (mem_op ? access & bus.bus_ack : 1'b1);
  assign bus.bus_request = access;
  assign bus.bus_write   = store_op;
  assign bus.bus_address = {memory_address[31:2], 2'b00};
  assign stall_request   = access & ~bus.bus_ack;
  assign mem_register_hi_write_enable = register_hi_write_enable_i;
  assign mem_register_lo_write_enable = register_lo_write_enable_i;
  assign mem_register_hi_write_data   = register_hi_write_data_i;
  assign mem_register_lo_write_data   = register_lo_write_data_i;
  always_comb begin
    state_d         = stall_request ? MEM_STATE_WAIT : MEM_STATE_IDLE;
    timer_d         = stall_request ? timer_q + 1'b1 : '0;
    bus_error_d     = live & state_q == MEM_STATE_WAIT & timer_q == TIMEOUT_T;
    address_error_d = mem_op & misaligned & ~flush;
    wb_d            = '0;
    if (commit) begin
      wb_d.we      = store_op ? WRITE_DISABLE : register_write_enable_i;
      wb_d.waddr   = register_write_address_i;
      wb_d.wdata   = store_op ? '0 : mem_op ? load_data : register_write_data_i;
      wb_d.hi_we   = register_hi_write_enable_i;
      wb_d.hi_data = register_hi_write_data_i;
      wb_d.lo_we   = register_lo_write_enable_i;
      wb_d.lo_data = register_lo_write_data_i;
    end
  end
  always_ff @(posedge clock) begin
    if (reset == RESET_ENABLE) begin
      state_q         <= MEM_STATE_IDLE;
      timer_q         <= '0;
      wb_q            <= '0;
      bus_error_q     <= 1'b0;
      address_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      wb_q            <= wb_d;
      bus_error_q     <= bus_error_d;
      address_error_q <= address_error_d;
    end
  end
  assign bus_error                   = bus_error_q;
  assign address_error               = address_error_q;
  assign wb_register_write_enable    = wb_q.we;
  assign wb_register_write_address   = wb_q.waddr;
  assign wb_register_write_data      = wb_q.wdata;
  assign wb_register_hi_write_enable = wb_q.hi_we;
  assign wb_register_hi_write_data   = wb_q.hi_data;
  assign wb_register_lo_write_enable = wb_q.lo_we;
  assign wb_register_lo_write_data   = wb_q.lo_data;
endmodule
